// File: rtl/motor_pkg.sv
// Shared definitions for the motor feedback path: quadrature codes, decoder
// states and the default velocity window for a 100 MHz clock.
package motor_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } dec_state_e;

  localparam int unsigned VEL_WINDOW_100M = 100000;

  // Phase of an AB code along the forward sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] qs_phase(input logic [1:0] ab);
    case (ab)
      QS_00:   qs_phase = 2'd0;
      QS_01:   qs_phase = 2'd1;
      QS_11:   qs_phase = 2'd2;
      default: qs_phase = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/enc_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter; `stable` is
// sticky once any run of FILT_LEN identical samples has been seen.
module enc_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk_100,
  input  logic resetN,
  input  logic raw,
  output logic filt,
  output logic stable
);

  localparam int unsigned RunW = $clog2(FILT_LEN + 1);

  logic [1:0]      sync_q;
  logic [1:0]      fill_q;
  logic            last_q;
  logic [RunW-1:0] run_q, run_d;
  logic            filt_q;
  logic            stable_q;

  // Samples still flushing through the synchronizer after reset are not counted.
  always_comb begin
    run_d = run_q;
    if (fill_q[1]) begin
      if (sync_q[1] != last_q) begin
        run_d = RunW'(1);
      end else if (run_q != RunW'(FILT_LEN)) begin
        run_d = run_q + RunW'(1);
      end
    end
  end

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      sync_q   <= '0;
      fill_q   <= '0;
      last_q   <= 1'b0;
      run_q    <= '0;
      filt_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fill_q <= {fill_q[0], 1'b1};
      run_q  <= run_d;
      if (fill_q[1]) begin
        last_q <= sync_q[1];
      end
      if (run_d == RunW'(FILT_LEN)) begin
        filt_q   <= sync_q[1];
        stable_q <= 1'b1;
      end
    end
  end

  assign filt   = filt_q;
  assign stable = stable_q;

endmodule

// File: rtl/quad_encoder_position.sv
// Quadrature encoder front end: filtered A/B/index decode into a signed position
// count, a windowed velocity sample and an illegal-transition counter.
module quad_encoder_position
  import motor_pkg::*;
#(
  parameter int unsigned POS_W      = 32,
  parameter int unsigned VEL_W      = 16,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned VEL_WINDOW = VEL_WINDOW_100M
) (
  input  logic                    clk_100,
  input  logic                    resetN,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_idx,
  input  logic                    zero_req,
  input  logic                    index_zero_en,
  output logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    err_pulse,
  output logic [7:0]              err_count
);

  localparam int unsigned AccW = $clog2(VEL_WINDOW + 1) + 1;
  localparam int unsigned SatW = (AccW > VEL_W) ? AccW : VEL_W;
  localparam int unsigned WinW = $clog2(VEL_WINDOW + 1);
  localparam logic signed [SatW-1:0] VelMax = SatW'({1'b0, {(VEL_W-1){1'b1}}});
  localparam logic signed [SatW-1:0] VelMin = ~VelMax;

  logic a_f, b_f, idx_f;
  logic a_st, b_st, idx_st;

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_100 (clk_100),
    .resetN  (resetN),
    .raw     (enc_a),
    .filt    (a_f),
    .stable  (a_st)
  );

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_100 (clk_100),
    .resetN  (resetN),
    .raw     (enc_b),
    .filt    (b_f),
    .stable  (b_st)
  );

  enc_filter #(.FILT_LEN(FILT_LEN)) u_filt_idx (
    .clk_100 (clk_100),
    .resetN  (resetN),
    .raw     (enc_idx),
    .filt    (idx_f),
    .stable  (idx_st)
  );

  dec_state_e              state_q;
  logic [1:0]              prev_ab_q;
  logic                    dir_q;
  logic                    err_pulse_q;
  logic [7:0]              err_count_q;
  logic                    idx_prev_q;
  logic signed [POS_W-1:0] pos_q;
  logic [WinW-1:0]         win_q;
  logic signed [AccW-1:0]  acc_q;
  logic signed [VEL_W-1:0] vel_q;
  logic                    vel_valid_q;

  logic [1:0]              ab;
  logic [1:0]              phase_delta;
  logic signed [1:0]       step;
  logic                    dbl;
  logic                    idx_rise;
  logic signed [AccW-1:0]  acc_sum;
  logic signed [SatW-1:0]  sum_ext;
  logic signed [VEL_W-1:0] vel_sat;

  assign ab          = {a_f, b_f};
  assign phase_delta = qs_phase(ab) - qs_phase(prev_ab_q);
  assign idx_rise    = idx_st & idx_f & ~idx_prev_q;

  // A phase advance of 2 means both channels moved at once: direction unknown.
  always_comb begin
    step = 2'sb00;
    dbl  = 1'b0;
    if (state_q == ST_TRACK) begin
      unique case (phase_delta)
        2'd1:    step = 2'sb01;
        2'd3:    step = 2'sb11;
        2'd2:    dbl  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_INIT;
      prev_ab_q   <= '0;
      dir_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= dbl;
      case (state_q)
        ST_INIT: begin
          if (a_st && b_st) begin
            prev_ab_q <= ab;
            state_q   <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          prev_ab_q <= ab;
          if (step == 2'sb01) begin
            dir_q <= 1'b1;
          end else if (step == 2'sb11) begin
            dir_q <= 1'b0;
          end
          if (dbl && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      pos_q      <= '0;
      idx_prev_q <= 1'b0;
    end else begin
      idx_prev_q <= idx_f;
      if (zero_req || (idx_rise && index_zero_en)) begin
        pos_q <= '0;
      end else begin
        pos_q <= pos_q + POS_W'(step);
      end
    end
  end

  // Velocity includes the terminal cycle's step; zero events never touch it.
  always_comb begin
    acc_sum = acc_q + AccW'(step);
    sum_ext = SatW'(acc_sum);
    if (sum_ext > VelMax) begin
      vel_sat = VelMax[VEL_W-1:0];
    end else if (sum_ext < VelMin) begin
      vel_sat = VelMin[VEL_W-1:0];
    end else begin
      vel_sat = sum_ext[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else if (win_q == WinW'(VEL_WINDOW - 1)) begin
      win_q       <= '0;
      acc_q       <= '0;
      vel_q       <= vel_sat;
      vel_valid_q <= 1'b1;
    end else begin
      win_q       <= win_q + WinW'(1);
      acc_q       <= acc_sum;
      vel_valid_q <= 1'b0;
    end
  end

  assign position  = pos_q;
  assign velocity  = vel_q;
  assign vel_valid = vel_valid_q;
  assign dir       = dir_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
